// File: rtl/rva_core_pkg.sv
// Core-wide constants shared by rename, dispatch and the physical register file.
package rva_core_pkg;

    localparam int unsigned PHY_REG_CNT = 64;
    localparam int unsigned PADDR_WIDTH = $clog2(PHY_REG_CNT);

    typedef logic [PADDR_WIDTH-1:0] rva_core_paddr_t;

endpackage

// File: rtl/rva_core_prf_pkg.sv
// Types and constants local to the physical register file.
package rva_core_prf_pkg;

    import rva_core_pkg::*;

    localparam int unsigned PRF_XLEN        = 64;
    localparam int unsigned PRF_AADDR_WIDTH = 5;

    localparam rva_core_paddr_t PRF_ZERO_PADDR = '0;

    typedef struct packed {
        logic                       we;
        logic [PRF_AADDR_WIDTH-1:0] aaddr;
        rva_core_paddr_t            paddr;
        logic [PRF_XLEN-1:0]        wdata;
    } rva_core_prf_wr_t;

endpackage

// File: rtl/rva_core_prf_sb.sv
// Per-register ready scoreboard: flush sets all, allocation clears, writeback sets.
module rva_core_prf_sb #(
    parameter int unsigned PHY_REG_CNT = 64,
    parameter int unsigned PAW         = $clog2(PHY_REG_CNT),
    parameter int unsigned NR          = 8,
    parameter int unsigned NW          = 4,
    parameter int unsigned NA          = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [NA-1:0]     alloc_valid_i,
    input  logic [NA*PAW-1:0] alloc_paddr_i,
    input  logic [NW-1:0]     wr_we_i,
    input  logic [NW*PAW-1:0] wr_paddr_i,
    input  logic [NR*PAW-1:0] rdy_paddr_i,
    output logic [NR-1:0]     rdy_o
);

    logic [PHY_REG_CNT-1:0] ready_q;
    logic [PHY_REG_CNT-1:0] ready_d;

    // Allocation is applied after writeback so the newer producer wins.
    always_comb begin
        ready_d = ready_q;
        for (int k = 0; k < int'(NW); k++) begin
            if (wr_we_i[k]) begin
                ready_d[wr_paddr_i[k*PAW +: PAW]] = 1'b1;
            end
        end
        for (int a = 0; a < int'(NA); a++) begin
            if (alloc_valid_i[a]) begin
                ready_d[alloc_paddr_i[a*PAW +: PAW]] = 1'b0;
            end
        end
        ready_d[0] = 1'b1;
        if (flush_i) begin
            ready_d = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= '1;
        end else begin
            ready_q <= ready_d;
        end
    end

    // Same-cycle wakeup: an enabled write counts as ready immediately.
    always_comb begin
        rdy_o = '0;
        for (int j = 0; j < int'(NR); j++) begin
            rdy_o[j] = ready_q[rdy_paddr_i[j*PAW +: PAW]];
            for (int k = 0; k < int'(NW); k++) begin
                if (wr_we_i[k] && (wr_paddr_i[k*PAW +: PAW] == rdy_paddr_i[j*PAW +: PAW])) begin
                    rdy_o[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rva_core_prf.sv
// Physical register file: NW write ports, NR registered read ports with write bypass,
// ready scoreboard and a writeback trace; p0 is hardwired to zero.
module rva_core_prf
    import rva_core_pkg::*;
    import rva_core_prf_pkg::*;
#(
    parameter int unsigned XLEN        = PRF_XLEN,
    parameter int unsigned PHY_REG_CNT = rva_core_pkg::PHY_REG_CNT,
    parameter int unsigned PAW         = $clog2(PHY_REG_CNT),
    parameter int unsigned NR          = 8,
    parameter int unsigned NW          = 4,
    parameter int unsigned NA          = 4,
    parameter bit          ASSERT_EN   = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NW-1:0]      wr_we_i,
    input  logic [NW*PAW-1:0]  wr_paddr_i,
    input  logic [NW*5-1:0]    wr_aaddr_i,
    input  logic [NW*XLEN-1:0] wr_wdata_i,
    input  logic [NR*PAW-1:0]  rd_paddr_i,
    output logic [NR*XLEN-1:0] rd_rdata_o,
    input  logic [NA-1:0]      alloc_valid_i,
    input  logic [NA*PAW-1:0]  alloc_paddr_i,
    input  logic [NR*PAW-1:0]  rdy_paddr_i,
    output logic [NR-1:0]      rdy_o,
    input  logic               flush_i,
    output logic               trc_valid_o,
    output logic [4:0]         trc_aaddr_o,
    output logic [PAW-1:0]     trc_paddr_o
);

    localparam int unsigned AAW = PRF_AADDR_WIDTH;

    rva_core_prf_wr_t wr [NW];
    logic [XLEN-1:0]  mem [PHY_REG_CNT];
    logic [XLEN-1:0]  rd_data_c [NR];
    rva_core_paddr_t  rd_paddr_c [NR];
    logic             wr_any_c;
    logic [AAW-1:0]   trc_aaddr_c;
    rva_core_paddr_t  trc_paddr_c;
    logic             ww_conflict_c;

    always_comb begin
        for (int k = 0; k < int'(NW); k++) begin
            wr[k].we    = wr_we_i[k];
            wr[k].aaddr = AAW'(wr_aaddr_i[k*5 +: 5]);
            wr[k].paddr = rva_core_paddr_t'(wr_paddr_i[k*PAW +: PAW]);
            wr[k].wdata = PRF_XLEN'(wr_wdata_i[k*XLEN +: XLEN]);
        end
    end

    // Storage is not reset; later ports overwrite earlier ones on a conflict.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < int'(NW); k++) begin
            if (wr[k].we && (wr[k].paddr != PRF_ZERO_PADDR)) begin
                mem[wr[k].paddr] <= XLEN'(wr[k].wdata);
            end
        end
    end

    // Read data with bypass from the highest matching write port.
    always_comb begin
        for (int j = 0; j < int'(NR); j++) begin
            rd_paddr_c[j] = rva_core_paddr_t'(rd_paddr_i[j*PAW +: PAW]);
            rd_data_c[j]  = (rd_paddr_c[j] == PRF_ZERO_PADDR) ? '0 : mem[rd_paddr_c[j]];
            for (int k = 0; k < int'(NW); k++) begin
                if (wr[k].we && (wr[k].paddr == rd_paddr_c[j]) &&
                    (rd_paddr_c[j] != PRF_ZERO_PADDR)) begin
                    rd_data_c[j] = XLEN'(wr[k].wdata);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_rdata_o <= '0;
        end else begin
            for (int j = 0; j < int'(NR); j++) begin
                rd_rdata_o[j*XLEN +: XLEN] <= rd_data_c[j];
            end
        end
    end

    // Trace follows the lowest-indexed enabled write port.
    always_comb begin
        wr_any_c    = 1'b0;
        trc_aaddr_c = '0;
        trc_paddr_c = '0;
        for (int k = int'(NW) - 1; k >= 0; k--) begin
            if (wr[k].we) begin
                wr_any_c    = 1'b1;
                trc_aaddr_c = wr[k].aaddr;
                trc_paddr_c = wr[k].paddr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trc_valid_o <= 1'b0;
            trc_aaddr_o <= '0;
            trc_paddr_o <= '0;
        end else begin
            trc_valid_o <= wr_any_c;
            if (wr_any_c) begin
                trc_aaddr_o <= 5'(trc_aaddr_c);
                trc_paddr_o <= PAW'(trc_paddr_c);
            end
        end
    end

    rva_core_prf_sb #(
        .PHY_REG_CNT (PHY_REG_CNT),
        .PAW         (PAW),
        .NR          (NR),
        .NW          (NW),
        .NA          (NA)
    ) u_sb (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_paddr_i (alloc_paddr_i),
        .wr_we_i       (wr_we_i),
        .wr_paddr_i    (wr_paddr_i),
        .rdy_paddr_i   (rdy_paddr_i),
        .rdy_o         (rdy_o)
    );

    // Two ports writing the same non-zero register means renaming broke.
    always_comb begin
        ww_conflict_c = 1'b0;
        for (int k = 0; k < int'(NW); k++) begin
            for (int l = k + 1; l < int'(NW); l++) begin
                if (wr[k].we && wr[l].we && (wr[k].paddr == wr[l].paddr) &&
                    (wr[k].paddr != PRF_ZERO_PADDR)) begin
                    ww_conflict_c = 1'b1;
                end
            end
        end
    end

    if (ASSERT_EN) begin : g_ww_chk
        a_no_ww_conflict: assert property (@(posedge clk_i) disable iff (!rst_ni) !ww_conflict_c);
    end

endmodule

// File: tb/tb_rva_core_prf.sv
// Directed and randomized bench for rva_core_prf against an array-based reference model.
module tb_rva_core_prf;

    localparam int XLEN = 64;
    localparam int NREG = 64;
    localparam int PAW  = 6;
    localparam int NR   = 8;
    localparam int NW   = 4;
    localparam int NA   = 4;

    logic               clk;
    logic               rst_n;
    logic [NW-1:0]      wr_we;
    logic [NW*PAW-1:0]  wr_paddr;
    logic [NW*5-1:0]    wr_aaddr;
    logic [NW*XLEN-1:0] wr_wdata;
    logic [NR*PAW-1:0]  rd_paddr;
    logic [NR*XLEN-1:0] rd_rdata;
    logic [NA-1:0]      alloc_valid;
    logic [NA*PAW-1:0]  alloc_paddr;
    logic [NR*PAW-1:0]  rdy_paddr;
    logic [NR-1:0]      rdy;
    logic               flush;
    logic               trc_valid;
    logic [4:0]         trc_aaddr;
    logic [PAW-1:0]     trc_paddr;

    rva_core_prf #(.ASSERT_EN(1'b0)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .wr_we_i       (wr_we),
        .wr_paddr_i    (wr_paddr),
        .wr_aaddr_i    (wr_aaddr),
        .wr_wdata_i    (wr_wdata),
        .rd_paddr_i    (rd_paddr),
        .rd_rdata_o    (rd_rdata),
        .alloc_valid_i (alloc_valid),
        .alloc_paddr_i (alloc_paddr),
        .rdy_paddr_i   (rdy_paddr),
        .rdy_o         (rdy),
        .flush_i       (flush),
        .trc_valid_o   (trc_valid),
        .trc_aaddr_o   (trc_aaddr),
        .trc_paddr_o   (trc_paddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: register contents, which are known, ready flags, expected outputs.
    logic [XLEN-1:0] m_mem   [NREG];
    bit              m_known [NREG];
    bit              m_ready [NREG];
    logic [XLEN-1:0] e_rdata [NR];
    bit              e_known [NR];
    logic            e_tv;
    logic [4:0]      e_ta;
    logic [PAW-1:0]  e_tp;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PAW-1:0] wpa(input int k);
        return wr_paddr[k*PAW +: PAW];
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NREG; p++) begin
            m_known[p] = (p == 0);
            m_ready[p] = 1'b1;
        end
        m_mem[0] = '0;
        for (int j = 0; j < NR; j++) begin
            e_rdata[j] = '0;
            e_known[j] = 1'b1;
        end
        e_tv = 1'b0;
        e_ta = '0;
        e_tp = '0;
    endtask

    task automatic clear_in();
        wr_we = '0; wr_paddr = '0; wr_aaddr = '0; wr_wdata = '0;
        rd_paddr = '0; rdy_paddr = '0;
        alloc_valid = '0; alloc_paddr = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int k, input logic [PAW-1:0] p, input logic [4:0] a,
                          input logic [XLEN-1:0] d);
        wr_we[k] = 1'b1;
        wr_paddr[k*PAW +: PAW] = p;
        wr_aaddr[k*5 +: 5] = a;
        wr_wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_alloc(input int a, input logic [PAW-1:0] p);
        alloc_valid[a] = 1'b1;
        alloc_paddr[a*PAW +: PAW] = p;
    endtask

    task automatic set_rd_all(input logic [PAW-1:0] p);
        for (int j = 0; j < NR; j++) rd_paddr[j*PAW +: PAW] = p;
    endtask

    task automatic set_q_all(input logic [PAW-1:0] p);
        for (int j = 0; j < NR; j++) rdy_paddr[j*PAW +: PAW] = p;
    endtask

    task automatic check_rdy();
        for (int j = 0; j < NR; j++) begin
            logic [PAW-1:0] q;
            bit exp;
            q = rdy_paddr[j*PAW +: PAW];
            exp = m_ready[q];
            for (int k = 0; k < NW; k++) if (wr_we[k] && wpa(k) == q) exp = 1'b1;
            chk($sformatf("rdy[%0d] p%0d", j, q), 64'(rdy[j]), 64'(exp));
        end
    endtask

    task automatic check_regs();
        for (int j = 0; j < NR; j++)
            if (e_known[j]) chk($sformatf("rdata[%0d]", j), rd_rdata[j*XLEN +: XLEN], e_rdata[j]);
        chk("trc_valid", 64'(trc_valid), 64'(e_tv));
        chk("trc_aaddr", 64'(trc_aaddr), 64'(e_ta));
        chk("trc_paddr", 64'(trc_paddr), 64'(e_tp));
    endtask

    // Apply the architectural effect of the inputs present at a rising edge.
    task automatic model_edge();
        bit nready [NREG];
        for (int j = 0; j < NR; j++) begin
            logic [PAW-1:0] p;
            p = rd_paddr[j*PAW +: PAW];
            if (p == 0) begin
                e_rdata[j] = '0; e_known[j] = 1'b1;
            end else begin
                e_rdata[j] = m_mem[p]; e_known[j] = m_known[p];
                for (int k = 0; k < NW; k++)
                    if (wr_we[k] && wpa(k) == p) begin
                        e_rdata[j] = wr_wdata[k*XLEN +: XLEN]; e_known[j] = 1'b1;
                    end
            end
        end
        for (int k = 0; k < NW; k++)
            if (wr_we[k] && wpa(k) != 0) begin
                m_mem[wpa(k)] = wr_wdata[k*XLEN +: XLEN];
                m_known[wpa(k)] = 1'b1;
            end
        for (int p = 0; p < NREG; p++) nready[p] = m_ready[p];
        for (int k = 0; k < NW; k++) if (wr_we[k]) nready[wpa(k)] = 1'b1;
        for (int a = 0; a < NA; a++)
            if (alloc_valid[a] && alloc_paddr[a*PAW +: PAW] != 0) nready[alloc_paddr[a*PAW +: PAW]] = 1'b0;
        for (int p = 0; p < NREG; p++) m_ready[p] = flush ? 1'b1 : nready[p];
        e_tv = |wr_we;
        for (int k = 0; k < NW; k++)
            if (wr_we[k]) begin
                e_ta = wr_aaddr[k*5 +: 5];
                e_tp = wpa(k);
                break;
            end
    endtask

    task automatic cycle();
        #1;
        check_rdy();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        model_reset();
        #12;
        check_regs();
        check_rdy();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state: p0 reads zero, everything ready, no trace.
        for (int j = 0; j < NR; j++) begin
            rd_paddr[j*PAW +: PAW]  = PAW'(j % 4);
            rdy_paddr[j*PAW +: PAW] = PAW'(j % 4);
        end
        cycle();
        chk("t1_rdata_p0", rd_rdata[XLEN-1:0], '0);
        chk("t1_trc_valid", 64'(trc_valid), 64'(0));

        // Give every register a known value.
        for (int base = 0; base < NREG; base += NW) begin
            clear_in();
            for (int k = 0; k < NW; k++)
                set_wr(k, PAW'(base + k), 5'($urandom), {$urandom, $urandom});
            cycle();
        end

        clear_in(); set_wr(0, 6'd5, 5'd7, 64'hDEAD_BEEF);
        cycle();
        clear_in(); set_rd_all(6'd5);
        cycle();
        chk("t2_p5", rd_rdata[XLEN-1:0], 64'hDEAD_BEEF);
        clear_in(); set_wr(0, 6'd0, 5'd1, 64'h1234);
        cycle();
        clear_in(); set_rd_all(6'd0);
        cycle();
        chk("t2_p0", rd_rdata[3*XLEN +: XLEN], '0);

        clear_in(); set_wr(1, 6'd9, 5'd3, 64'hA5); set_rd_all(6'd9);
        cycle();
        chk("t3_bypass", rd_rdata[XLEN-1:0], 64'hA5);
        clear_in(); set_wr(0, 6'd9, 5'd4, 64'h11); set_wr(3, 6'd9, 5'd5, 64'h33);
        cycle();
        clear_in(); set_rd_all(6'd9);
        cycle();
        chk("t3_ww_high_wins", rd_rdata[XLEN-1:0], 64'h33);

        clear_in(); set_alloc(0, 6'd12); set_q_all(6'd12);
        cycle();
        clear_in(); set_q_all(6'd12);
        #1 chk("t4_alloc_clears", 64'(rdy[0]), 64'(0));
        cycle();
        clear_in(); set_q_all(6'd12); set_wr(2, 6'd12, 5'd9, 64'h77);
        #1 chk("t4_wakeup", 64'(rdy[1]), 64'(1));
        cycle();
        clear_in(); set_q_all(6'd12); set_wr(0, 6'd12, 5'd9, 64'h78); set_alloc(1, 6'd12);
        cycle();
        clear_in(); set_q_all(6'd12);
        #1 chk("t4_alloc_beats_wb", 64'(rdy[2]), 64'(0));
        cycle();

        clear_in();
        for (int a = 0; a < NA; a++) set_alloc(a, PAW'(20 + a));
        cycle();
        clear_in(); set_alloc(0, 6'd24); flush = 1'b1;
        for (int j = 0; j < 5; j++) rdy_paddr[j*PAW +: PAW] = PAW'(20 + j);
        #1 chk("t5_pre_flush_p20", 64'(rdy[0]), 64'(0));
        cycle();
        clear_in();
        for (int j = 0; j < 5; j++) rdy_paddr[j*PAW +: PAW] = PAW'(20 + j);
        #1;
        for (int j = 0; j < 5; j++) chk($sformatf("t5_flush_p%0d", 20 + j), 64'(rdy[j]), 64'(1));
        cycle();

        // Randomized traffic with distinct write addresses per cycle.
        for (int n = 0; n < 400; n++) begin
            clear_in();
            for (int k = 0; k < NW; k++) begin
                if ($urandom_range(0, 2) != 0) begin
                    logic [PAW-1:0] p;
                    bit clash;
                    do begin
                        p = PAW'($urandom_range(0, NREG - 1));
                        clash = 1'b0;
                        for (int l = 0; l < k; l++) if (wr_we[l] && wpa(l) == p && p != 0) clash = 1'b1;
                    end while (clash);
                    set_wr(k, p, 5'($urandom), {$urandom, $urandom});
                end
            end
            for (int j = 0; j < NR; j++) begin
                rd_paddr[j*PAW +: PAW]  = PAW'($urandom_range(0, NREG - 1));
                rdy_paddr[j*PAW +: PAW] = PAW'($urandom_range(0, NREG - 1));
            end
            for (int a = 0; a < NA; a++)
                if ($urandom_range(0, 3) == 0) set_alloc(a, PAW'($urandom_range(0, NREG - 1)));
            flush = ($urandom_range(0, 39) == 0);
            cycle();
        end

        // Asynchronous reset between edges while writes are in flight.
        clear_in();
        set_wr(0, 6'd30, 5'd2, 64'hCAFE); set_wr(2, 6'd31, 5'd6, 64'hF00D);
        set_alloc(0, 6'd40);
        for (int j = 0; j < NR; j++) rdy_paddr[j*PAW +: PAW] = PAW'(40 + j);
        cycle();
        chk("t6_pre_trc_valid", 64'(trc_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_rdy();
        chk("t6_rdata0_zero", rd_rdata[XLEN-1:0], '0);
        chk("t6_p40_ready", 64'(rdy[0]), 64'(1));
        clear_in();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_rd_all(6'd0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
